sigma_delta_adc: RTL and testbench

- Digital half of a first-order sigma-delta ADC. It is the input-side counterpart of the codebase's sigma-delta DAC and targets cassette/audio input.
- An external comparator compares the analog input against an RC integrator. The integrator is driven by this block's feedback pin.
- The block synchronises the comparator, registers the feedback bit and decimates the bitstream with a boxcar counter.
- It delivers one excess-2^MSBI code per window through a valid/ready holding register with sticky overrun.

---
 rtl/sigma_delta_adc.sv | 115 +++++++++++
 tb/tb_sigma_delta_adc.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_adc.sv
// Digital half of a first-order sigma-delta ADC: comparator synchroniser, feedback
// flop for the RC integrator, boxcar decimator and a valid/ready sample holding register.
module sigma_delta_adc #(
  parameter int MSBI       = 7,
  parameter int DECIM_LOG2 = 8
) (
  input  logic          clk_i,
  input  logic          res_n_i,
  input  logic          en_i,
  input  logic          cmp_i,
  output logic          fb_o,
  output logic [MSBI:0] sample_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          overrun_o,
  input  logic          clr_ovr_i
);

  if (DECIM_LOG2 < MSBI + 1) begin : g_bad_params
    $error("sigma_delta_adc: DECIM_LOG2 must be >= MSBI+1");
  end

  localparam int SHIFT = DECIM_LOG2 - MSBI - 1;
  localparam logic [DECIM_LOG2-1:0] CNT_ONE = 1;
  localparam logic [DECIM_LOG2:0]   ACC_ZERO = '0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic                  cmp_s1_q, cmp_s1_d;
  logic                  cmp_s2_q, cmp_s2_d;
  logic                  fb_q, fb_d;
  logic [DECIM_LOG2:0]   acc_q, acc_d;
  logic [DECIM_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [MSBI:0]         sample_q, sample_d;
  state_t                state_q, state_d;
  logic                  ovr_q, ovr_d;

  logic                  win_end;
  logic [DECIM_LOG2:0]   total;
  logic [DECIM_LOG2:0]   shifted;
  logic [MSBI:0]         code;

  // A full window of ones (2^DECIM_LOG2) lands one bit above the output range and saturates.
  assign win_end = en_i && (win_cnt_q == '1);
  assign total   = acc_q + {ACC_ZERO[DECIM_LOG2:1], fb_q};
  assign shifted = total >> SHIFT;
  assign code    = (|shifted[DECIM_LOG2:MSBI+1]) ? '1 : shifted[MSBI:0];

  always_comb begin
    cmp_s1_d  = cmp_i;
    cmp_s2_d  = cmp_s1_q;
    fb_d      = cmp_s2_q;
    acc_d     = '0;
    win_cnt_d = '0;
    if (en_i) begin
      win_cnt_d = win_cnt_q + CNT_ONE;
      acc_d     = win_end ? '0 : total;
    end
  end

  always_comb begin
    sample_d = sample_q;
    state_d  = state_q;
    ovr_d    = ovr_q && !clr_ovr_i;
    case (state_q)
      EMPTY: begin
        if (win_end) begin
          sample_d = code;
          state_d  = FULL;
        end
      end
      FULL: begin
        if (win_end) begin
          // A consumer taking the old sample on the same edge frees the slot for the new one.
          if (ready_i) sample_d = code;
          else         ovr_d    = 1'b1;
        end else if (ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      cmp_s1_q  <= 1'b0;
      cmp_s2_q  <= 1'b0;
      fb_q      <= 1'b0;
      acc_q     <= '0;
      win_cnt_q <= '0;
      sample_q  <= '0;
      state_q   <= EMPTY;
      ovr_q     <= 1'b0;
    end else begin
      cmp_s1_q  <= cmp_s1_d;
      cmp_s2_q  <= cmp_s2_d;
      fb_q      <= fb_d;
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
      sample_q  <= sample_d;
      state_q   <= state_d;
      ovr_q     <= ovr_d;
    end
  end

  assign fb_o      = fb_q;
  assign sample_o  = sample_q;
  assign valid_o   = (state_q == FULL);
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Bench for sigma_delta_adc: directed scenarios plus random bitstreams, scored against
// a window-sum reference model through an expected-sample queue.
module tb_sigma_delta_adc;

  localparam int MSBI       = 7;
  localparam int DECIM_LOG2 = 8;
  localparam int WIN        = 1 << DECIM_LOG2;
  localparam int SHIFT      = DECIM_LOG2 - MSBI - 1;
  localparam int MAXC       = (1 << (MSBI + 1)) - 1;

  logic          clk_i;
  logic          res_n_i;
  logic          en_i;
  logic          cmp_i;
  logic          fb_o;
  logic [MSBI:0] sample_o;
  logic          valid_o;
  logic          ready_i;
  logic          overrun_o;
  logic          clr_ovr_i;

  sigma_delta_adc #(.MSBI(MSBI), .DECIM_LOG2(DECIM_LOG2)) dut (
    .clk_i    (clk_i),
    .res_n_i  (res_n_i),
    .en_i     (en_i),
    .cmp_i    (cmp_i),
    .fb_o     (fb_o),
    .sample_o (sample_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .overrun_o(overrun_o),
    .clr_ovr_i(clr_ovr_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_checks;
  int n_fail;
  int last_acc;

  // Reference model state, valid after each clock edge.
  bit fb_pipe[$];
  bit m_fb;
  bit m_valid;
  bit m_ovr;
  int m_sample;
  int m_cnt;
  int m_sum;
  int m_windows;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    fb_pipe.delete();
    fb_pipe.push_back(1'b0);
    fb_pipe.push_back(1'b0);
    m_fb = 0; m_valid = 0; m_ovr = 0; m_sample = 0;
    m_cnt = 0; m_sum = 0;
    exp_q.delete();
  endtask

  // Advances the model across the coming rising edge using the inputs now applied.
  task automatic model_update();
    bit win, accept, set_ovr;
    int code;
    if (!res_n_i) begin
      model_reset();
      return;
    end
    fb_pipe.push_back(cmp_i);
    win  = 0;
    code = 0;
    if (en_i) begin
      m_sum += int'(m_fb);
      m_cnt++;
      if (m_cnt == WIN) begin
        win  = 1;
        code = m_sum >> SHIFT;
        if (code > MAXC) code = MAXC;
        m_cnt = 0;
        m_sum = 0;
        m_windows++;
      end
    end else begin
      m_cnt = 0;
      m_sum = 0;
    end
    accept  = m_valid && ready_i;
    set_ovr = 0;
    if (win) begin
      if (!m_valid || accept) begin
        m_sample = code;
        m_valid  = 1;
        exp_q.push_back(code);
      end else begin
        set_ovr = 1;
      end
    end else if (accept) begin
      m_valid = 0;
    end
    if (set_ovr)        m_ovr = 1;
    else if (clr_ovr_i) m_ovr = 0;
    m_fb = fb_pipe.pop_front();
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic step();
    model_update();
    @(negedge clk_i);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_until_last();
    int guard = 0;
    while (m_cnt != WIN - 1 && guard < 2 * WIN) begin
      step();
      guard++;
    end
    check("align_last_cycle", m_cnt, WIN - 1);
  endtask

  task automatic run_until_windows(input int target);
    int guard = 0;
    while (m_windows < target && guard < 3 * WIN) begin
      step();
      guard++;
    end
    check("window_wait", m_windows, target);
  endtask

  task automatic edges_to_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!valid_o && n < 2 * WIN);
  endtask

  // Monitor: scores each accepted sample and tracks the model every cycle.
  initial begin
    bit pv;
    int ps;
    int e;
    pv = 0;
    ps = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!res_n_i) begin
        pv = 0;
      end else if (pv && ready_i) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_sample", ps, -1);
        end else begin
          e = exp_q.pop_front();
          check("sb_sample", ps, e);
          last_acc = ps;
          $display("txn t=%0t sample=0x%02h expected=0x%02h", $time, ps, e);
        end
      end
      check("valid_o", valid_o, m_valid);
      check("overrun_o", overrun_o, m_ovr);
      check("fb_o", fb_o, m_fb);
      if (valid_o) check("sample_o_held", sample_o, m_sample);
      pv = valid_o;
      ps = sample_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int w0;
    int held;
    int vcount;
    int dens;
    int en_off;
    bit hold_low;
    n_checks = 0;
    n_fail   = 0;
    last_acc = -1;
    m_windows = 0;
    res_n_i = 1'b1; en_i = 1'b0; cmp_i = 1'b0; ready_i = 1'b0; clr_ovr_i = 1'b0;
    model_reset();
    #1 res_n_i = 1'b0;
    #2;
    check("reset_fb", fb_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_sample", sample_o, 0);
    check("reset_ovr", overrun_o, 0);
    @(negedge clk_i);
    run(2);

    // Constant ones from reset release: 3 dead cycles then saturation.
    cmp_i = 1'b1; en_i = 1'b1; ready_i = 1'b1; res_n_i = 1'b1;
    step(); check("fb_edge1", fb_o, 0);
    step(); check("fb_edge2", fb_o, 0);
    step(); check("fb_edge3", fb_o, 1);
    edges = 3;
    while (!valid_o && edges < 2 * WIN) begin
      step();
      edges++;
    end
    // Registered at edge 256, i.e. visible during cycle 257.
    check("first_valid_edge", edges, WIN);
    check("first_sample", sample_o, 8'hFD);
    run(3 * WIN);
    check("saturated_sample", last_acc, 8'hFF);
    check("p1_no_overrun", overrun_o, 0);

    // Zeros, then alternating bits.
    cmp_i = 1'b0;
    run(3 * WIN);
    check("zero_sample", last_acc, 8'h00);
    for (int i = 0; i < 3 * WIN; i++) begin
      cmp_i = ~cmp_i;
      step();
    end
    check("midscale_sample", last_acc, 8'h80);

    // Stalled consumer across two window ends.
    ready_i = 1'b0;
    cmp_i = 1'b0;
    w0 = m_windows;
    run_until_windows(w0 + 1);
    held = m_sample;
    check("held_valid", valid_o, 1);
    cmp_i = 1'b1;
    run_until_windows(w0 + 2);
    check("overrun_set", overrun_o, 1);
    check("sample_unchanged", sample_o, held);
    clr_ovr_i = 1'b1; step(); clr_ovr_i = 1'b0;
    check("overrun_cleared", overrun_o, 0);
    run_until_last();
    clr_ovr_i = 1'b1; step(); clr_ovr_i = 1'b0;
    check("overrun_set_wins", overrun_o, 1);

    // Consumer accepts exactly on a window-end edge.
    clr_ovr_i = 1'b1; step(); clr_ovr_i = 1'b0;
    check("overrun_cleared2", overrun_o, 0);
    run_until_last();
    ready_i = 1'b1;
    step();
    check("accept_on_end_valid", valid_o, 1);
    check("accept_on_end_ovr", overrun_o, 0);
    check("accept_on_end_sample", sample_o, 8'hFF);
    step();
    check("drained", valid_o, 0);

    // Enable dropped mid-window; modulator keeps running.
    run_until_last();
    run(2);
    run(50);
    en_i = 1'b0;
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      cmp_i = (i < 90) ? 1'($urandom_range(1)) : 1'b1;
      step();
      if (valid_o) vcount++;
    end
    check("no_valid_while_disabled", vcount, 0);
    en_i = 1'b1;
    edges_to_valid(edges);
    check("reenable_valid_edge", edges, WIN);
    check("reenable_full_window", sample_o, 8'hFF);
    step();

    // Asynchronous reset with a held sample and overrun pending.
    ready_i = 1'b0;
    w0 = m_windows;
    run_until_windows(w0 + 2);
    run(30);
    check("pre_reset_valid", valid_o, 1);
    check("pre_reset_ovr", overrun_o, 1);
    #2 res_n_i = 1'b0;
    model_reset();
    #1;
    check("async_rst_fb", fb_o, 0);
    check("async_rst_valid", valid_o, 0);
    check("async_rst_sample", sample_o, 0);
    check("async_rst_ovr", overrun_o, 0);
    @(negedge clk_i);
    run(2);
    res_n_i = 1'b1; ready_i = 1'b1; cmp_i = 1'b1;
    edges_to_valid(edges);
    check("post_reset_valid_edge", edges, WIN);
    check("post_reset_sample", sample_o, 8'hFD);

    // Random bitstreams, back-pressure, clears and enable drops.
    en_off = 0;
    dens = 50;
    hold_low = 0;
    for (int i = 0; i < 10 * WIN; i++) begin
      if (i % WIN == 0) begin
        dens = $urandom_range(100);
        hold_low = ($urandom_range(3) == 0);
      end
      cmp_i     = ($urandom_range(99) < dens);
      ready_i   = hold_low ? 1'b0 : ($urandom_range(7) != 0);
      clr_ovr_i = ($urandom_range(63) == 0);
      if (en_off == 0 && $urandom_range(999) == 0) en_off = $urandom_range(40, 1);
      en_i = (en_off == 0);
      if (en_off > 0) en_off--;
      step();
    end
    clr_ovr_i = 1'b0;
    en_i = 1'b1;
    ready_i = 1'b1;
    run(4);
    check("sb_residual", exp_q.size(), int'(m_valid));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
